// File: rtl/shake256_absorb_padder_if.sv
// Message-word input stream and rate-block output stream of the SHAKE256 absorb padder.
interface shake256_absorb_padder_if #(
  parameter int unsigned RATE_BYTES = 136
);
  logic                      din_valid;
  logic                      din_ready;
  logic [31:0]               din;
  logic                      din_last;
  logic [2:0]                din_bytes;
  logic                      blk_valid;
  logic                      blk_ready;
  logic [8*RATE_BYTES-1:0]   blk_data;
  logic                      blk_first;
  logic                      blk_last;

  modport master (
    output din_valid, din, din_last, din_bytes, blk_ready,
    input  din_ready, blk_valid, blk_data, blk_first, blk_last
  );

  modport slave (
    input  din_valid, din, din_last, din_bytes, blk_ready,
    output din_ready, blk_valid, blk_data, blk_first, blk_last
  );
endinterface

// File: rtl/shake256_absorb_padder.sv
// SHAKE256 absorb front end: packs 32-bit message words into rate blocks and
// applies pad10*1 with the 0x1F domain suffix, flagging first/last blocks.
module shake256_absorb_padder #(
  parameter int unsigned RATE_BYTES = 136
) (
  input  logic                      clk,
  input  logic                      rst,
  shake256_absorb_padder_if.slave   bus
);
  localparam int unsigned WORDS_PER_BLOCK = RATE_BYTES / 4;
  localparam int unsigned BLK_W           = 8 * RATE_BYTES;
  localparam int unsigned WCNT_W          = (WORDS_PER_BLOCK > 1) ? $clog2(WORDS_PER_BLOCK) : 1;
  localparam int unsigned IDX_W           = $clog2(BLK_W);

  localparam logic [1:0] ST_FILL = 2'd0;
  localparam logic [1:0] ST_OUT  = 2'd1;
  localparam logic [1:0] ST_PAD  = 2'd2;

  logic [1:0]        state, state_nx;
  logic [WCNT_W-1:0] wcnt, wcnt_nx;
  logic [BLK_W-1:0]  blk, blk_nx;
  logic              blk_valid;
  logic              blk_first, blk_first_nx;
  logic              blk_last, blk_last_nx;
  logic              first_pend, first_pend_nx;
  logic              pad_pend, pad_pend_nx;

  logic              accept_c;
  logic [2:0]        nbytes_c;
  logic [31:0]       word_c;
  int unsigned       pad_pos_c;
  logic [IDX_W-1:0]  word_idx_c;
  logic [IDX_W-1:0]  pad_idx_c;

  assign bus.din_ready = (state == ST_FILL) && !rst;
  assign accept_c      = bus.din_valid && bus.din_ready;

  assign bus.blk_valid = blk_valid;
  assign bus.blk_data  = blk;
  assign bus.blk_first = blk_first;
  assign bus.blk_last  = blk_last;

  // Incoming word with bytes beyond the valid count zeroed, plus its slot and pad position.
  always_comb begin
    word_c = '0;
    if (!bus.din_last) begin
      nbytes_c = 3'd4;
    end else if (bus.din_bytes > 3'd4) begin
      nbytes_c = 3'd4;
    end else begin
      nbytes_c = bus.din_bytes;
    end
    for (int k = 0; k < 4; k++) begin
      word_c[8*k +: 8] = (3'(k) < nbytes_c) ? bus.din[8*k +: 8] : 8'h00;
    end
    pad_pos_c  = 4 * 32'(wcnt) + 32'(nbytes_c);
    word_idx_c = IDX_W'(wcnt) << 5;
    pad_idx_c  = IDX_W'(pad_pos_c) << 3;
  end

  // Next-state and next-register logic.
  always_comb begin
    state_nx      = state;
    wcnt_nx       = wcnt;
    blk_nx        = blk;
    blk_first_nx  = blk_first;
    blk_last_nx   = blk_last;
    first_pend_nx = first_pend;
    pad_pend_nx   = pad_pend;

    case (state)
      ST_FILL: begin
        if (accept_c) begin
          blk_nx[word_idx_c +: 32] = word_c;
          if (bus.din_last) begin
            state_nx      = ST_OUT;
            wcnt_nx       = '0;
            blk_first_nx  = first_pend;
            first_pend_nx = 1'b0;
            if (pad_pos_c < RATE_BYTES) begin
              // Suffix and final pad bit may share a byte, giving 0x9F.
              blk_nx[pad_idx_c +: 8]  = blk_nx[pad_idx_c +: 8] ^ 8'h1F;
              blk_nx[BLK_W-8 +: 8]    = blk_nx[BLK_W-8 +: 8] ^ 8'h80;
              blk_last_nx             = 1'b1;
            end else begin
              blk_last_nx = 1'b0;
              pad_pend_nx = 1'b1;
            end
          end else if (wcnt == WCNT_W'(WORDS_PER_BLOCK - 1)) begin
            state_nx      = ST_OUT;
            wcnt_nx       = '0;
            blk_last_nx   = 1'b0;
            blk_first_nx  = first_pend;
            first_pend_nx = 1'b0;
          end else begin
            wcnt_nx = wcnt + WCNT_W'(1);
          end
        end
      end
      ST_OUT: begin
        if (bus.blk_ready) begin
          blk_nx  = '0;
          wcnt_nx = '0;
          if (pad_pend) begin
            state_nx = ST_PAD;
          end else begin
            state_nx = ST_FILL;
            if (blk_last) begin
              first_pend_nx = 1'b1;
            end
          end
        end
      end
      ST_PAD: begin
        // Message filled the last block exactly: emit a pad-only block.
        blk_nx               = '0;
        blk_nx[7:0]          = 8'h1F;
        blk_nx[BLK_W-8 +: 8] = 8'h80;
        blk_first_nx         = 1'b0;
        blk_last_nx          = 1'b1;
        pad_pend_nx          = 1'b0;
        first_pend_nx        = 1'b0;
        state_nx             = ST_OUT;
      end
      default: begin
        state_nx = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_FILL;
      wcnt       <= '0;
      blk        <= '0;
      blk_valid  <= 1'b0;
      blk_first  <= 1'b0;
      blk_last   <= 1'b0;
      first_pend <= 1'b1;
      pad_pend   <= 1'b0;
    end else begin
      state      <= state_nx;
      wcnt       <= wcnt_nx;
      blk        <= blk_nx;
      blk_valid  <= (state_nx == ST_OUT);
      blk_first  <= blk_first_nx;
      blk_last   <= blk_last_nx;
      first_pend <= first_pend_nx;
      pad_pend   <= pad_pend_nx;
    end
  end
endmodule

// File: tb/tb_shake256_absorb_padder.sv
// Directed bench for shake256_absorb_padder: padding, block flags, stalls and reset.
module tb_shake256_absorb_padder;
  localparam int unsigned RB  = 136;
  localparam int unsigned BW  = 8 * RB;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shake256_absorb_padder_if #(.RATE_BYTES(RB)) bus ();
  shake256_absorb_padder #(.RATE_BYTES(RB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int tmo      = 0;

  logic [7:0]    eb  [RB];
  logic [7:0]    msg [300];
  logic [BW-1:0] exp_blk;
  logic [BW-1:0] snap;
  int            di;
  int            bad;

  function automatic logic [BW-1:0] pack_exp();
    logic [BW-1:0] r;
    for (int i = 0; i < int'(RB); i++) r[8*i +: 8] = eb[i];
    return r;
  endfunction

  function automatic int diff_byte(input logic [BW-1:0] a, input logic [BW-1:0] b);
    for (int i = 0; i < int'(RB); i++) if (a[8*i +: 8] !== b[8*i +: 8]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] msg_word(input int w);
    return {msg[4*w+3], msg[4*w+2], msg[4*w+1], msg[4*w]};
  endfunction

  task automatic clear_exp();
    for (int i = 0; i < int'(RB); i++) eb[i] = 8'h00;
  endtask

  // Presents one word from a negedge and returns #1 after the accepting edge.
  task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
    bit got;
    got = 1'b0;
    @(negedge clk);
    bus.din_valid = 1'b1; bus.din = d; bus.din_last = last; bus.din_bytes = nb;
    for (int c = 0; c < 200; c++) begin
      if (bus.din_ready === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (got) begin @(posedge clk); #1; end
    else tmo++;
    bus.din_valid = 1'b0; bus.din_last = 1'b0;
  endtask

  task automatic wait_valid();
    bit got;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (bus.blk_valid === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) tmo++;
  endtask

  // Called at a negedge with blk_valid high; completes one handshake.
  task automatic take_block();
    bus.blk_ready = 1'b1;
    @(posedge clk); #1;
    bus.blk_ready = 1'b0;
  endtask

  task automatic test_reset();
    bus.din_valid = 1'b1; bus.din = 32'h12345678; bus.din_last = 1'b1;
    bus.din_bytes = 3'd4; bus.blk_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.din_ready !== 1'b0) begin failures++; $display("FAIL reset din_ready got=%b exp=0", bus.din_ready); end
    checks++; if (bus.blk_valid !== 1'b0) begin failures++; $display("FAIL reset blk_valid got=%b exp=0", bus.blk_valid); end
    checks++; if (bus.blk_first !== 1'b0) begin failures++; $display("FAIL reset blk_first got=%b exp=0", bus.blk_first); end
    checks++; if (bus.blk_last !== 1'b0) begin failures++; $display("FAIL reset blk_last got=%b exp=0", bus.blk_last); end
    checks++; if (bus.blk_data !== '0) begin failures++; $display("FAIL reset blk_data nonzero byte %0d", diff_byte(bus.blk_data, '0)); end
    bus.din_valid = 1'b0; bus.din_last = 1'b0;
    rst = 1'b0;
    #1;
    checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL reset_release din_ready got=%b exp=1", bus.din_ready); end
    @(negedge clk);
    checks++; if (bus.blk_valid !== 1'b0) begin failures++; $display("FAIL reset_release blk_valid got=%b exp=0", bus.blk_valid); end
  endtask

  task automatic test_empty();
    send_word(32'h0, 1'b1, 3'd0);
    @(negedge clk);
    clear_exp(); eb[0] = 8'h1F; eb[RB-1] = 8'h80; exp_blk = pack_exp();
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL empty blk_valid got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_data !== exp_blk) begin failures++; di = diff_byte(bus.blk_data, exp_blk);
      $display("FAIL empty data byte %0d got=%h exp=%h", di, bus.blk_data[8*di +: 8], exp_blk[8*di +: 8]); end
    checks++; if ({bus.blk_first, bus.blk_last} !== 2'b11) begin failures++; $display("FAIL empty flags got=%b exp=11", {bus.blk_first, bus.blk_last}); end
    take_block();
    @(negedge clk);
    checks++; if ({bus.din_ready, bus.blk_valid} !== 2'b10) begin failures++; $display("FAIL empty after_take ready/valid got=%b exp=10", {bus.din_ready, bus.blk_valid}); end
    checks++; if (tmo !== 0) begin failures++; $display("FAIL empty timeouts got=%0d exp=0", tmo); tmo = 0; end
  endtask

  task automatic test_abc();
    send_word(32'h00636261, 1'b1, 3'd3);
    @(negedge clk);
    clear_exp(); eb[0] = 8'h61; eb[1] = 8'h62; eb[2] = 8'h63; eb[3] = 8'h1F; eb[RB-1] = 8'h80;
    exp_blk = pack_exp();
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL abc blk_valid got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_data !== exp_blk) begin failures++; di = diff_byte(bus.blk_data, exp_blk);
      $display("FAIL abc data byte %0d got=%h exp=%h", di, bus.blk_data[8*di +: 8], exp_blk[8*di +: 8]); end
    checks++; if ({bus.blk_first, bus.blk_last} !== 2'b11) begin failures++; $display("FAIL abc flags got=%b exp=11", {bus.blk_first, bus.blk_last}); end
    take_block();
    checks++; if (tmo !== 0) begin failures++; $display("FAIL abc timeouts got=%0d exp=0", tmo); tmo = 0; end
  endtask

  task automatic test_135_bytes();
    for (int k = 0; k < 135; k++) msg[k] = 8'(k + 1);
    msg[135] = 8'hAA;
    for (int w = 0; w < 34; w++) send_word(msg_word(w), (w == 33), 3'd3);
    @(negedge clk);
    clear_exp();
    for (int k = 0; k < 135; k++) eb[k] = msg[k];
    eb[RB-1] = 8'h9F;
    exp_blk = pack_exp();
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL len135 blk_valid got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_data !== exp_blk) begin failures++; di = diff_byte(bus.blk_data, exp_blk);
      $display("FAIL len135 data byte %0d got=%h exp=%h", di, bus.blk_data[8*di +: 8], exp_blk[8*di +: 8]); end
    checks++; if ({bus.blk_first, bus.blk_last} !== 2'b11) begin failures++; $display("FAIL len135 flags got=%b exp=11", {bus.blk_first, bus.blk_last}); end
    take_block();
    checks++; if (tmo !== 0) begin failures++; $display("FAIL len135 timeouts got=%0d exp=0", tmo); tmo = 0; end
  endtask

  task automatic test_136_bytes();
    for (int k = 0; k < 136; k++) msg[k] = 8'(255 - k);
    for (int w = 0; w < 34; w++) send_word(msg_word(w), (w == 33), 3'd4);
    @(negedge clk);
    clear_exp();
    for (int k = 0; k < 136; k++) eb[k] = msg[k];
    exp_blk = pack_exp();
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL len136_a blk_valid got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_data !== exp_blk) begin failures++; di = diff_byte(bus.blk_data, exp_blk);
      $display("FAIL len136_a data byte %0d got=%h exp=%h", di, bus.blk_data[8*di +: 8], exp_blk[8*di +: 8]); end
    checks++; if ({bus.blk_first, bus.blk_last} !== 2'b10) begin failures++; $display("FAIL len136_a flags got=%b exp=10", {bus.blk_first, bus.blk_last}); end
    take_block();
    @(negedge clk);
    checks++; if ({bus.din_ready, bus.blk_valid} !== 2'b00) begin failures++; $display("FAIL len136 bubble ready/valid got=%b exp=00", {bus.din_ready, bus.blk_valid}); end
    @(negedge clk);
    clear_exp(); eb[0] = 8'h1F; eb[RB-1] = 8'h80; exp_blk = pack_exp();
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL len136_b blk_valid got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_data !== exp_blk) begin failures++; di = diff_byte(bus.blk_data, exp_blk);
      $display("FAIL len136_b data byte %0d got=%h exp=%h", di, bus.blk_data[8*di +: 8], exp_blk[8*di +: 8]); end
    checks++; if ({bus.blk_first, bus.blk_last} !== 2'b01) begin failures++; $display("FAIL len136_b flags got=%b exp=01", {bus.blk_first, bus.blk_last}); end
    take_block();
    @(negedge clk);
    checks++; if (bus.din_ready !== 1'b1) begin failures++; $display("FAIL len136 after_take din_ready got=%b exp=1", bus.din_ready); end
    checks++; if (tmo !== 0) begin failures++; $display("FAIL len136 timeouts got=%0d exp=0", tmo); tmo = 0; end
  endtask

  task automatic test_stall_300();
    int nw;
    for (int k = 0; k < 300; k++) msg[k] = 8'(k * 7 + 3);
    for (int j = 0; j < 3; j++) begin
      nw = (j < 2) ? 34 : 7;
      for (int w = 0; w < nw; w++) send_word(msg_word(34*j + w), (j == 2 && w == nw - 1), 3'd4);
      @(negedge clk);
      wait_valid();
      clear_exp();
      if (j < 2) begin
        for (int k = 0; k < 136; k++) eb[k] = msg[136*j + k];
      end else begin
        for (int k = 0; k < 28; k++) eb[k] = msg[272 + k];
        eb[28] = 8'h1F; eb[RB-1] = 8'h80;
      end
      exp_blk = pack_exp();
      checks++; if (bus.blk_data !== exp_blk) begin failures++; di = diff_byte(bus.blk_data, exp_blk);
        $display("FAIL len300 blk%0d data byte %0d got=%h exp=%h", j, di, bus.blk_data[8*di +: 8], exp_blk[8*di +: 8]); end
      checks++; if ({bus.blk_first, bus.blk_last} !== {(j == 0), (j == 2)}) begin failures++;
        $display("FAIL len300 blk%0d flags got=%b exp=%b", j, {bus.blk_first, bus.blk_last}, {(j == 0), (j == 2)}); end
      // Stall with junk offered on the input; it must not be taken.
      bus.din_valid = 1'b1; bus.din = 32'hFFFF_FFFF; bus.din_last = 1'b1; bus.din_bytes = 3'd4;
      snap = bus.blk_data; bad = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (bus.din_ready !== 1'b0 || bus.blk_valid !== 1'b1 || bus.blk_data !== snap) bad++;
      end
      bus.din_valid = 1'b0; bus.din_last = 1'b0;
      checks++; if (bad !== 0) begin failures++; $display("FAIL len300 blk%0d stall bad_cycles got=%0d exp=0", j, bad); end
      take_block();
    end
    checks++; if (tmo !== 0) begin failures++; $display("FAIL len300 timeouts got=%0d exp=0", tmo); tmo = 0; end
  endtask

  task automatic test_reset_mid();
    for (int w = 0; w < 10; w++) send_word(msg_word(w), 1'b0, 3'd4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({bus.din_ready, bus.blk_valid} !== 2'b00) begin failures++; $display("FAIL rst_mid ready/valid got=%b exp=00", {bus.din_ready, bus.blk_valid}); end
    rst = 1'b0;
    send_word(32'hDEADBEEF, 1'b1, 3'd4);
    @(negedge clk);
    clear_exp(); eb[0] = 8'hEF; eb[1] = 8'hBE; eb[2] = 8'hAD; eb[3] = 8'hDE; eb[4] = 8'h1F; eb[RB-1] = 8'h80;
    exp_blk = pack_exp();
    checks++; if (bus.blk_valid !== 1'b1) begin failures++; $display("FAIL rst_mid blk_valid got=%b exp=1", bus.blk_valid); end
    checks++; if (bus.blk_data !== exp_blk) begin failures++; di = diff_byte(bus.blk_data, exp_blk);
      $display("FAIL rst_mid data byte %0d got=%h exp=%h", di, bus.blk_data[8*di +: 8], exp_blk[8*di +: 8]); end
    checks++; if ({bus.blk_first, bus.blk_last} !== 2'b11) begin failures++; $display("FAIL rst_mid flags got=%b exp=11", {bus.blk_first, bus.blk_last}); end
    take_block();
    checks++; if (tmo !== 0) begin failures++; $display("FAIL rst_mid timeouts got=%0d exp=0", tmo); tmo = 0; end
  endtask

  task automatic test_back_to_back();
    send_word(32'h00636261, 1'b1, 3'd3);
    @(negedge clk);
    checks++; if ({bus.blk_valid, bus.blk_first, bus.blk_last} !== 3'b111) begin failures++;
      $display("FAIL b2b msg1 valid/first/last got=%b exp=111", {bus.blk_valid, bus.blk_first, bus.blk_last}); end
    take_block();
    // din_bytes above 4 counts as a full word.
    send_word(32'h44332211, 1'b1, 3'd7);
    @(negedge clk);
    clear_exp(); eb[0] = 8'h11; eb[1] = 8'h22; eb[2] = 8'h33; eb[3] = 8'h44; eb[4] = 8'h1F; eb[RB-1] = 8'h80;
    exp_blk = pack_exp();
    checks++; if ({bus.blk_valid, bus.blk_first, bus.blk_last} !== 3'b111) begin failures++;
      $display("FAIL b2b msg2 valid/first/last got=%b exp=111", {bus.blk_valid, bus.blk_first, bus.blk_last}); end
    checks++; if (bus.blk_data !== exp_blk) begin failures++; di = diff_byte(bus.blk_data, exp_blk);
      $display("FAIL b2b msg2 data byte %0d got=%h exp=%h", di, bus.blk_data[8*di +: 8], exp_blk[8*di +: 8]); end
    take_block();
    checks++; if (tmo !== 0) begin failures++; $display("FAIL b2b timeouts got=%0d exp=0", tmo); tmo = 0; end
  endtask

  initial begin
    test_reset();
    test_empty();
    test_abc();
    test_135_bytes();
    test_136_bytes();
    test_stall_300();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
